// File: rtl/flog_pkg.sv
// flog_pkg: FSM state type and bfloat16 constants shared by the flog arbiter.
package flog_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [15:0] BF16_NEG_INF = 16'hFF80;
    localparam logic [15:0] BF16_POS_INF = 16'h7F80;
    localparam logic [15:0] BF16_ONE     = 16'h3F80;
    localparam logic [15:0] BF16_ZERO    = 16'h0000;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    assign gnt = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/flog_arb.sv
// flog_arb: shares one flog unit between two requesters, resolving special
// operands locally and aborting the unit after TIMEOUT_CYC silent cycles.
module flog_arb
    import flog_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid_i,
    input  logic [15:0] req_op0_i,
    input  logic [15:0] req_op1_i,
    output logic [1:0]  req_ready_o,
    output logic        unit_start_o,
    output logic [15:0] unit_op_o,
    input  logic        unit_valid_i,
    input  logic [15:0] unit_res_i,
    output logic        unit_flush_o,
    output logic [1:0]  rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    input  logic [1:0]  rsp_ready_i
);
    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d, owner_q, owner_d, err_q, err_d, flush_q, flush_d;
    logic [15:0] op_q, op_d, res_q, res_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [1:0]  gnt;
    logic [15:0] sel_op, spec_res;
    logic        spec_hit, is_nan, exp_zero, accept;

    rr_arb2 u_rr (.req(req_valid_i), .last_grant(last_q), .gnt(gnt));

    // Decoding on the granted operand bus lets a special operand reach RESP one cycle after accept.
    always_comb begin
        sel_op   = gnt[1] ? req_op1_i : req_op0_i;
        exp_zero = sel_op[14:7] == 8'h00;
        is_nan   = (sel_op[14:7] == 8'hFF) && (sel_op[6:0] != 7'd0);
        spec_hit = exp_zero || sel_op[15] || is_nan || sel_op == BF16_POS_INF || sel_op == BF16_ONE;
        spec_res = exp_zero ? BF16_NEG_INF :
                   (sel_op[15] || is_nan) ? BF16_QNAN :
                   (sel_op == BF16_POS_INF) ? BF16_POS_INF : BF16_ZERO;
        accept   = (state_q == IDLE) && (gnt != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        flush_d = 1'b0;
        cnt_d   = (state_q == WAIT) ? cnt_q + 7'd1 : 7'd0;
        unique case (state_q)
            IDLE: if (accept) begin
                last_d  = gnt[1];
                owner_d = gnt[1];
                op_d    = sel_op;
                res_d   = spec_res;
                err_d   = 1'b0;
                state_d = spec_hit ? RESP : ISSUE;
            end
            ISSUE: state_d = WAIT;
            // A result arriving on the timeout cycle still wins over the abort.
            WAIT: if (unit_valid_i) begin
                res_d   = unit_res_i;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
                res_d   = BF16_QNAN;
                err_d   = 1'b1;
                flush_d = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready_i[owner_q]) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= 16'h0000;
            res_q   <= 16'h0000;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready_o  = (rst && state_q == IDLE) ? gnt : 2'b00;
    assign unit_start_o = state_q == ISSUE;
    assign unit_op_o    = (state_q == ISSUE) ? op_q : 16'h0000;
    assign unit_flush_o = flush_q;
    assign rsp_valid_o  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data_o   = (state_q == RESP) ? res_q : 16'h0000;
    assign rsp_err_o    = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_flog_arb.sv
// tb_flog_arb: table, directed and random transactions on flog_arb, checked
// against a transaction-level model of grant order, results and latency.
module tb_flog_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [15:0] req_op0_i, req_op1_i, unit_op_o, unit_res_i, rsp_data_o;
    logic        unit_start_o, unit_valid_i, unit_flush_o, rsp_err_o;
    int          n_vec = 0, n_bad = 0, cyc = 0;
    int          ucnt = 0, cur_lat = 0, n_start = 0, n_flush = 0, start_cyc = 0;
    logic [15:0] start_op = 16'h0000, ures = 16'h0000;
    logic        last_m = 1'b1;

    typedef struct {
        logic [15:0] op;
        logic        byp;
        logic [15:0] res;
    } vec_t;
    vec_t tab[15];

    flog_arb dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_op0_i(req_op0_i), .req_op1_i(req_op1_i),
        .req_ready_o(req_ready_o),
        .unit_start_o(unit_start_o), .unit_op_o(unit_op_o),
        .unit_valid_i(unit_valid_i), .unit_res_i(unit_res_i), .unit_flush_o(unit_flush_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .rsp_ready_i(rsp_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural flog unit: answers op^16'h5A5A cur_lat cycles after start; cur_lat = 0 means silent.
    initial begin
        unit_valid_i = 1'b0;
        unit_res_i   = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            unit_valid_i = 1'b0;
            if (!rst) ucnt = 0;
            else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    unit_valid_i = 1'b1;
                    unit_res_i   = ures;
                end
            end
            #3;
            if (unit_start_o) begin
                n_start++;
                start_op  = unit_op_o;
                start_cyc = cyc;
                ucnt      = cur_lat;
                ures      = unit_op_o ^ 16'h5A5A;
            end
            if (unit_flush_o) n_flush++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] all_out();
        return {25'd0, req_ready_o, unit_start_o, unit_op_o, unit_flush_o, rsp_valid_o, rsp_data_o, rsp_err_o};
    endfunction

    function automatic void ref_spec(input logic [15:0] x, output logic hit, output logic [15:0] r);
        logic [7:0] e;
        e   = x[14:7];
        hit = 1'b1;
        if (e == 8'h00) r = 16'hFF80;
        else if (x[15]) r = 16'h7FC0;
        else if (x == 16'h7F80) r = 16'h7F80;
        else if (e == 8'hFF) r = 16'h7FC0;
        else if (x == 16'h3F80) r = 16'h0000;
        else begin
            hit = 1'b0;
            r   = 16'h0000;
        end
    endfunction

    task automatic txn(input logic [1:0] vm, input logic [15:0] o0, input logic [15:0] o1,
                       input int lat, input int hold, input logic keep,
                       input logic tab_on, input logic tbyp, input logic [15:0] tres);
        logic w, to, byp;
        logic [15:0] op, ed, bres;
        int c, lat_e, acc;
        w  = (vm == 2'b11) ? ~last_m : vm[1];
        op = w ? o1 : o0;
        if (tab_on) begin
            byp  = tbyp;
            bres = tres;
        end else ref_spec(op, byp, bres);
        to    = !byp && (lat < 1 || lat > 64);
        lat_e = byp ? 1 : (to ? 66 : 2 + lat);
        ed    = byp ? bres : (to ? 16'h7FC0 : op ^ 16'h5A5A);
        tick();
        cur_lat = lat;
        n_start = 0;
        n_flush = 0;
        req_valid_i = vm;
        req_op0_i   = o0;
        req_op1_i   = o1;
        rsp_ready_i = 2'b00;
        #2;
        acc = cyc;
        chk("grant", req_ready_o, oh(w));
        tick();
        req_valid_i = keep ? (vm & ~oh(w)) : 2'b00;
        #2;
        c = 1;
        while (rsp_valid_o == 2'b00 && c < 80) begin
            tick();
            #2;
            c++;
        end
        chk("latency", c, lat_e);
        chk("rsp", {rsp_valid_o, rsp_data_o, rsp_err_o}, {oh(w), ed, to});
        for (int i = 0; i < hold; i++) begin
            tick();
            rsp_ready_i = ~oh(w);
            #2;
            chk("hold", {req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o}, {2'b00, oh(w), ed, to});
        end
        tick();
        rsp_ready_i = oh(w);
        #2;
        tick();
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b00;
        #2;
        chk("idle", {rsp_valid_o, rsp_data_o, rsp_err_o}, 64'd0);
        chk("starts", n_start, byp ? 0 : 1);
        chk("flushes", n_flush, to ? 1 : 0);
        if (!byp) chk("start_op", {start_op, 32'(start_cyc - acc)}, {op, 32'd1});
        last_m = w;
    endtask

    initial begin
        tab = '{
            '{16'h0000, 1'b1, 16'hFF80}, '{16'hC000, 1'b1, 16'h7FC0}, '{16'h3F80, 1'b1, 16'h0000},
            '{16'h8000, 1'b1, 16'hFF80}, '{16'h0001, 1'b1, 16'hFF80}, '{16'h8042, 1'b1, 16'hFF80},
            '{16'hFF80, 1'b1, 16'h7FC0}, '{16'hFFC1, 1'b1, 16'h7FC0}, '{16'h7F80, 1'b1, 16'h7F80},
            '{16'h7FC0, 1'b1, 16'h7FC0}, '{16'h7F81, 1'b1, 16'h7FC0}, '{16'hBF80, 1'b1, 16'h7FC0},
            '{16'h4000, 1'b0, 16'h0000}, '{16'h3F81, 1'b0, 16'h0000}, '{16'h0080, 1'b0, 16'h0000}
        };
        rst = 1'b0;
        req_valid_i = 2'b11;
        req_op0_i   = 16'h4000;
        req_op1_i   = 16'h4040;
        rsp_ready_i = 2'b11;
        tick();
        chk("reset_out", all_out(), 64'd0);
        tick();
        chk("reset_out2", all_out(), 64'd0);
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        rst = 1'b1;
        txn(2'b11, 16'h4000, 16'h4040, 1, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
        txn(2'b11, 16'h4000, 16'h4040, 3, 2, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 15; i++)
            txn((i % 2 == 1) ? 2'b10 : 2'b01, tab[i].op, tab[i].op, 2, 0, 1'b0, 1'b1, tab[i].byp, tab[i].res);
        txn(2'b01, 16'h4100, 16'h0000, 70, 10, 1'b0, 1'b0, 1'b0, 16'h0000);
        txn(2'b10, 16'h0000, 16'h656B, 64, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
        txn(2'b11, 16'h4000, 16'h4040, 2, 10, 1'b1, 1'b0, 1'b0, 16'h0000);
        txn(2'b11, 16'h4000, 16'h4040, 2, 10, 1'b1, 1'b0, 1'b0, 16'h0000);
        // Reset while the unit is being waited on.
        tick();
        cur_lat = 0;
        n_start = 0;
        n_flush = 0;
        req_valid_i = 2'b11;
        req_op0_i   = 16'h4000;
        req_op1_i   = 16'h4040;
        #2;
        chk("pre_rst_grant", req_ready_o, oh(~last_m));
        tick();
        tick();
        chk("pre_rst_start", n_start, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_out", all_out(), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("rst_hold_out", all_out(), 64'd0);
        end
        req_valid_i = 2'b00;
        rst = 1'b1;
        last_m = 1'b1;
        tick();
        #2;
        chk("post_rst_out", all_out(), 64'd0);
        chk("rst_no_flush", n_flush, 0);
        txn(2'b11, 16'h4000, 16'h4040, 1, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            logic [15:0] sp[8];
            logic [15:0] a, b;
            int r, lat;
            sp = '{16'h0000, 16'h8000, 16'hC000, 16'hFF80, 16'h7F80, 16'h7FC1, 16'h3F80, 16'h0042};
            a = ($urandom_range(0, 1) == 1) ? sp[$urandom_range(0, 7)] : 16'($urandom);
            b = ($urandom_range(0, 1) == 1) ? sp[$urandom_range(0, 7)] : 16'($urandom);
            r = int'($urandom_range(0, 9));
            lat = (r < 7) ? int'($urandom_range(1, 6)) : (r == 7) ? 64 : (r == 8) ? 0 : int'($urandom_range(7, 63));
            txn(2'($urandom_range(1, 3)), a, b, lat, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'b0, 1'b0, 16'h0000);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/flog_arb.md
FLOG_ARB -- requirements
Module: flog_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum number of WAIT cycles before the operation is aborted.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  2  per-requester operand valid; bit k belongs to requester k.
REQ-005 req_op0_i, req_op1_i  input  16 each  bfloat16 operands (sign 15, exp 14:7, fract 6:0).
REQ-006 req_ready_o  output  2  per-requester operand accept.
REQ-007 unit_start_o  output  1  one-cycle start pulse to the shared flog unit.
REQ-008 unit_op_o  output  16  operand to the flog unit, valid while unit_start_o is high.
REQ-009 unit_valid_i  input  1  flog unit result valid, one-cycle pulse.
REQ-010 unit_res_i  input  16  flog unit result {sgn, exp, fract}.
REQ-011 unit_flush_o  output  1  one-cycle abort pulse to the flog unit.
REQ-012 rsp_valid_o  output  2  per-requester response valid; at most one bit set.
REQ-013 rsp_data_o  output  16  bfloat16 result for the owning requester.
REQ-014 rsp_err_o  output  1  result produced by timeout.
REQ-015 rsp_ready_i  input  2  per-requester response accept.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one operation SHALL be outstanding at a time.
REQ-017 In IDLE, req_ready_o SHALL be set combinationally for the granted requester only; all other states SHALL drive req_ready_o = 0.
REQ-018 Grant SHALL be round-robin: a sole valid requester wins; if both are valid, the requester not granted last wins; last_grant SHALL update on every accept.
REQ-019 On accept, the block SHALL latch the operand and owner, then go to ISSUE, or to RESP for special operands.
REQ-020 Special operands SHALL bypass the unit and reach RESP in 1 cycle. exp=0 (zero or denormal, either sign) SHALL give 16'hFF80. Any other negative SHALL give 16'h7FC0. 16'h7F80 SHALL give 16'h7F80. NaN (exp=8'hFF, fract!=0) SHALL give 16'h7FC0. 16'h3F80 SHALL give 16'h0000.
REQ-021 ISSUE SHALL last exactly 1 cycle, asserting unit_start_o with unit_op_o equal to the latched operand, and SHALL then go to WAIT.
REQ-022 In WAIT, a 7-bit counter SHALL increment each cycle, starting from 0.
REQ-023 In WAIT, unit_valid_i = 1 SHALL capture unit_res_i and go to RESP with error = 0.
REQ-024 If the counter reaches TIMEOUT_CYC-1 with unit_valid_i = 0, the block SHALL pulse unit_flush_o, set the result to 16'h7FC0 and error = 1, and go to RESP.
REQ-025 If unit_valid_i and the timeout occur in the same cycle, the valid result SHALL win and no flush SHALL be issued.
REQ-026 unit_valid_i SHALL be ignored outside WAIT.
REQ-027 In RESP, rsp_valid_o[owner] SHALL be held with rsp_data_o and rsp_err_o stable until rsp_ready_i[owner] = 1, then go to IDLE.
REQ-028 rsp_ready_i of the non-owner SHALL be ignored.
REQ-029 Minimum latency SHALL be: accept to rsp_valid = 2 + unit latency cycles (normal path) and 1 cycle (bypass). Back-to-back accepts SHALL be separated by at least 1 IDLE cycle.
REQ-030 rsp_data_o and rsp_err_o SHALL read 0 outside RESP.

Reset
REQ-031 While rst = 0, the state SHALL be IDLE, last_grant = 1 (requester 0 wins first tie), counter = 0, and latched operand/result = 0.
REQ-032 While rst = 0, all outputs SHALL be 0.
REQ-033 Reset mid-operation SHALL drop the operation without a flush pulse and without any response.

Structure
REQ-034 flog_pkg SHALL hold the FSM state enum and the constants BF16_QNAN=16'h7FC0, BF16_NEG_INF=16'hFF80, BF16_POS_INF=16'h7F80, BF16_ONE=16'h3F80, BF16_ZERO=16'h0000.
REQ-035 Round-robin grant SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant; output gnt[1:0], one-hot or zero).
REQ-036 Special-operand decode SHALL be combinational inside flog_arb.

Verification
REQ-037 Both valid after reset, op0=16'h4000, op1=16'h4040 -> requester 0 granted first; unit_start_o with 16'h4000 one cycle after accept; requester 1 served next.
REQ-038 op=16'h0000, then op=16'hC000, then op=16'h3F80 -> rsp_data 16'hFF80, 16'h7FC0, 16'h0000; unit_start_o never asserted.
REQ-039 Unit silent for 64 WAIT cycles -> unit_flush_o pulse, rsp_data 16'h7FC0, rsp_err_o = 1; a later unit_valid_i pulse is ignored.
REQ-040 unit_valid_i on the exact timeout cycle with res=16'h3F31 -> rsp_data 16'h3F31, err = 0, no flush.
REQ-041 rsp_ready_i held 0 for 10 cycles with the other requester valid -> rsp_valid and data stable; no accept until handshake completes.
REQ-042 rst asserted during WAIT -> all outputs 0 immediately; after release, requester 0 wins the first tie.
